// File: rtl/ones_ctrl_pkg.sv
// Shared state encoding and width helper for the serial ones-count controller.
package ones_ctrl_pkg;

   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_SHIFT = 2'b01;
   localparam logic [1:0] S_DONE  = 2'b10;

   // Bits needed to hold a count of 0..w inclusive.
   function automatic int unsigned cw_of(input int unsigned w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/ones_shift_dp.sv
// Bit-serial ones-count datapath: shift register, accumulator and bit pointer.
// ONES_COUNT_EARLY_EXIT_EN compiles in the "no ones remain" comparator.
module ones_shift_dp
   import ones_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned CW    = cw_of(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_load,
   input  logic             i_shift,
   input  logic [WIDTH-1:0] i_data,
   output logic             o_last,
   output logic             o_rem_zero,
   output logic [CW-1:0]    o_next_count
);

   logic [WIDTH-1:0] r_shreg;
   logic [CW-1:0]    r_acc;
   logic [CW-1:0]    r_ptr;

   assign o_next_count = r_acc + CW'(r_shreg[0]);
   assign o_last       = (r_ptr == CW'(1));

`ifdef ONES_COUNT_EARLY_EXIT_EN
   assign o_rem_zero = ((r_shreg >> 1) == '0);
`else
   assign o_rem_zero = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         r_shreg <= '0;
         r_acc   <= '0;
         r_ptr   <= '0;
      end else if (i_load) begin
         r_shreg <= i_data;
         r_acc   <= '0;
         r_ptr   <= CW'(WIDTH);
      end else if (i_shift) begin
         r_shreg <= r_shreg >> 1;
         r_acc   <= o_next_count;
         r_ptr   <= r_ptr - CW'(1);
      end
   end

endmodule

// File: rtl/ones_count_ctrl.sv
// Control unit for the serial ones-count: IDLE/SHIFT/DONE FSM plus the result register.
// Early exit is selected inside ones_shift_dp by ONES_COUNT_EARLY_EXIT_EN.
module ones_count_ctrl
   import ones_ctrl_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [WIDTH-1:0]         data_in,
   output logic                     ready,
   output logic                     busy,
   output logic                     done,
   output logic [cw_of(WIDTH)-1:0]  count
);

   localparam int unsigned CW = cw_of(WIDTH);

   logic [1:0]    r_state;
   logic [1:0]    w_state_d;
   logic [CW-1:0] r_count;
   logic          w_load;
   logic          w_shift;
   logic          w_last;
   logic          w_rem_zero;
   logic          w_exit;
   logic [CW-1:0] w_next_count;

   assign w_load  = (r_state == S_IDLE) && start;
   assign w_shift = (r_state == S_SHIFT);
   assign w_exit  = w_last || w_rem_zero;

   ones_shift_dp #(
      .WIDTH (WIDTH),
      .CW    (CW)
   ) u_dp (
      .clk          (clk),
      .reset        (reset),
      .i_load       (w_load),
      .i_shift      (w_shift),
      .i_data       (data_in),
      .o_last       (w_last),
      .o_rem_zero   (w_rem_zero),
      .o_next_count (w_next_count)
   );

   always_comb begin
      w_state_d = r_state;
      case (r_state)
         S_IDLE:  if (start) w_state_d = S_SHIFT;
         S_SHIFT: if (w_exit) w_state_d = S_DONE;
         S_DONE:  w_state_d = S_IDLE;
         default: w_state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_count <= '0;
      end else begin
         r_state <= w_state_d;
         // Result lands on the same edge that enters DONE.
         if (w_shift && w_exit) r_count <= w_next_count;
      end
   end

   assign ready = (r_state == S_IDLE);
   assign busy  = (r_state == S_SHIFT) || (r_state == S_DONE);
   assign done  = (r_state == S_DONE);
   assign count = r_count;

endmodule

// File: tb/tb_ones_count_ctrl.sv
// Self-checking bench for ones_count_ctrl: directed boundary words plus random words
// checked against a popcount/latency reference model.
module tb_ones_count_ctrl;

   localparam int unsigned W  = 8;
   localparam int unsigned CW = $clog2(W + 1);

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          start = 1'b0;
   logic [W-1:0]  data_in = '0;
   logic          ready;
   logic          busy;
   logic          done;
   logic [CW-1:0] count;

   int n_checks = 0;
   int n_errors = 0;

   ones_count_ctrl #(
      .WIDTH (W)
   ) u_dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .data_in (data_in),
      .ready   (ready),
      .busy    (busy),
      .done    (done),
      .count   (count)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int popcount(input logic [W-1:0] d);
      int n = 0;
      for (int i = 0; i < int'(W); i++) n += int'(d[i]);
      return n;
   endfunction

   // Number of SHIFT cycles the controller should spend on word d.
   function automatic int shift_cycles(input logic [W-1:0] d);
`ifdef ONES_COUNT_EARLY_EXIT_EN
      int hi = 0;
      for (int i = 0; i < int'(W); i++) if (d[i]) hi = i;
      return hi + 1;
`else
      return int'(W);
`endif
   endfunction

   // Accept one word, optionally toggling start/data during SHIFT, and check the result.
   task automatic run_word(input logic [W-1:0] d, input bit noise, input logic [W-1:0] nd);
      int lat;
      int exp_lat;
      exp_lat = shift_cycles(d) + 1;
      @(negedge clk);
      check_eq("ready_before_req", ready, 1);
      start   = 1'b1;
      data_in = d;
      @(negedge clk);
      start   = noise;
      data_in = nd;
      check_eq("busy_after_accept", busy, 1);
      check_eq("ready_after_accept", ready, 0);
      lat = 1;
      while (!done && lat < 64) begin
         @(negedge clk);
         lat++;
         if (noise) begin
            start   = 1'($urandom_range(0, 1));
            data_in = W'($urandom);
         end
      end
      start = 1'b0;
      check_eq("done_latency", lat, exp_lat);
      check_eq("count_value", count, popcount(d));
      check_eq("busy_in_done", busy, 1);
      @(negedge clk);
      check_eq("done_one_cycle", done, 0);
      check_eq("ready_after_done", ready, 1);
      check_eq("count_holds", count, popcount(d));
   endtask

   initial begin
      int t_first;
      int t_second;
      int c_first;
      int c_second;
      int cyc;
      bit saw_done;

      // Reset held for two edges.
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      check_eq("rst_ready", ready, 1);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_count", count, 0);
      repeat (3) @(negedge clk);
      check_eq("idle_stays_ready", ready, 1);
      check_eq("idle_no_busy", busy, 0);

      run_word(8'hA5, 1'b0, '0);
      run_word(8'hFF, 1'b0, '0);
      run_word(8'h00, 1'b0, '0);
      run_word(8'h03, 1'b0, '0);
      run_word(8'h80, 1'b0, '0);
      run_word(8'hF0, 1'b1, 8'h0F);

      // Back-to-back with start held high; second word presented during SHIFT.
      @(negedge clk);
      start   = 1'b1;
      data_in = 8'hFF;
      @(negedge clk);
      data_in = 8'h01;
      t_first = -1;
      t_second = -1;
      c_first = -1;
      c_second = -1;
      for (cyc = 1; cyc < 60 && t_second < 0; cyc++) begin
         if (done) begin
            if (t_first < 0) begin
               t_first = cyc;
               c_first = int'(count);
            end else begin
               t_second = cyc;
               c_second = int'(count);
               start = 1'b0;
            end
         end
         @(negedge clk);
      end
      start = 1'b0;
      check_eq("b2b_first_count", c_first, 8);
      check_eq("b2b_second_count", c_second, 1);
      check_eq("b2b_spacing", t_second - t_first, 2 + shift_cycles(8'h01));
      check_eq("b2b_ready_after", ready, 1);

      // Reset asserted so that it lands on the 3rd SHIFT edge of 8'hFF (prior count nonzero).
      run_word(8'hA5, 1'b0, '0);
      @(negedge clk);
      start   = 1'b1;
      data_in = 8'hFF;
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_eq("midrst_ready", ready, 1);
      check_eq("midrst_count", count, 0);
      check_eq("midrst_busy", busy, 0);
      saw_done = 1'b0;
      repeat (12) begin
         @(negedge clk);
         if (done) saw_done = 1'b1;
      end
      check_eq("midrst_no_done", saw_done, 0);

      // Random words, half of them with start/data noise during SHIFT.
      for (int i = 0; i < 25; i++) begin
         logic [W-1:0] d;
         d = W'($urandom);
         if (i % 5 == 0) d = d & W'($urandom);
         run_word(d, 1'($urandom_range(0, 1)), W'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
